matmul_result_streamer: RTL and testbench

- Downstream stage of the matmul datapath.
- On a `load` pulse, snapshots the full C[M][N] accumulator array into shadow registers and serialises it row-major onto an AXI4-Stream master port.
- Narrows each element from ACC_W to OUT_W on the way out.
- Frees the datapath to clear and start the next tile while the previous result drains.

---
 rtl/matmul_result_streamer_pkg.sv | 50 +++++
 rtl/matmul_result_streamer_if.sv | 21 ++
 rtl/matmul_result_streamer.sv | 135 +++++++++++++
 tb/tb_matmul_result_streamer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_result_streamer_pkg.sv
// matmul_pkg: shared state type, index-width helper and element narrowing for matmul_result_streamer.
// Defining MATMUL_STREAM_SAT_EN makes sat_narrow saturate; otherwise it keeps the low bits (wrap).
package matmul_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  // Widest accumulator the narrowing helper can handle.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             clipped;
  } narrow_t;

  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // The caller keeps data[out_w-1:0]. In wrap mode, dropping the upper bits is the narrowing itself.
  function automatic narrow_t sat_narrow(input logic signed [MAX_W-1:0] value,
                                         input int                      acc_w,
                                         input int                      out_w);
    narrow_t res;
`ifdef MATMUL_STREAM_SAT_EN
    logic signed [MAX_W-1:0] max_v;
    logic signed [MAX_W-1:0] min_v;
`endif
    res.data    = value;
    res.clipped = 1'b0;
    if (out_w >= acc_w) begin
      return res;
    end
`ifdef MATMUL_STREAM_SAT_EN
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (value > max_v) begin
      res.data    = max_v;
      res.clipped = 1'b1;
    end else if (value < min_v) begin
      res.data    = min_v;
      res.clipped = 1'b1;
    end
`endif
    return res;
  endfunction

endpackage

// File: rtl/matmul_result_streamer_if.sv
// AXI4-Stream style result port for matmul_result_streamer.
// sat_flag exists only when MATMUL_STREAM_SAT_EN is defined.
interface matmul_result_streamer_if #(
  parameter int OUT_W = 16
);

  logic signed [OUT_W-1:0] tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
`ifdef MATMUL_STREAM_SAT_EN
  logic                    sat_flag;

  modport master (output tdata, output tvalid, output tlast, output sat_flag, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input sat_flag, output tready);
`else
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif

endinterface

// File: rtl/matmul_result_streamer.sv
// Snapshots the C accumulator array on load and streams it row-major, narrowed to OUT_W, over AXI4-Stream.
// Optional build macro MATMUL_STREAM_SAT_EN: saturating narrowing plus a per-beat sat_flag.
module matmul_result_streamer
  import matmul_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int M     = 2,
  parameter int N     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic signed [ACC_W-1:0]       C [M][N],
  output logic                          busy,
  output logic                          load_drop,
  output logic                          done,
  matmul_result_streamer_if.master      m_axis
);

  localparam int                 BEATS    = M * N;
  localparam int                 IDX_W    = idx_width(BEATS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(BEATS - 1);

  stream_state_t            state;
  stream_state_t            state_next;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         idx_next;
  logic                     capture;
  logic                     done_next;
  logic                     drop_next;
  logic                     handshake;
  logic                     final_hs;
  logic                     stream_valid;
  logic signed [ACC_W-1:0]  shadow [BEATS];
  logic signed [ACC_W-1:0]  sel_value;
  logic signed [OUT_W-1:0]  sel_data;

  function automatic logic signed [OUT_W-1:0] narrow_data(input logic signed [ACC_W-1:0] v);
    narrow_t n;
    n = sat_narrow(MAX_W'(v), ACC_W, OUT_W);
    return n.data[OUT_W-1:0];
  endfunction

`ifdef MATMUL_STREAM_SAT_EN
  function automatic logic narrow_clipped(input logic signed [ACC_W-1:0] v);
    narrow_t n;
    n = sat_narrow(MAX_W'(v), ACC_W, OUT_W);
    return n.clipped;
  endfunction
`endif

  assign stream_valid = (state == STREAM);
  assign handshake    = stream_valid && m_axis.tready;
  assign final_hs     = handshake && (idx == LAST_IDX);

  // A load on the final handshake restarts the frame directly, so back-to-back tiles have no bubble.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    done_next  = 1'b0;
    drop_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (final_hs) begin
          done_next = 1'b1;
          if (load) begin
            capture  = 1'b1;
            idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (handshake) begin
            idx_next = idx + 1'b1;
          end
          if (load) begin
            drop_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      done      <= 1'b0;
      load_drop <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      done      <= done_next;
      load_drop <= drop_next;
    end
  end

  // The shadow copy is stored flat in row-major order, so idx addresses it directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BEATS; i++) begin
        shadow[i] <= '0;
      end
    end else if (capture) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          shadow[r*N + c] <= C[r][c];
        end
      end
    end
  end

  assign sel_value = shadow[idx];
  assign sel_data  = narrow_data(sel_value);

  assign busy          = stream_valid;
  assign m_axis.tvalid = stream_valid;
  assign m_axis.tdata  = stream_valid ? sel_data : '0;
  assign m_axis.tlast  = stream_valid && (idx == LAST_IDX);

`ifdef MATMUL_STREAM_SAT_EN
  assign m_axis.sat_flag = stream_valid && narrow_clipped(sel_value);
`endif

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Randomised scoreboard bench for matmul_result_streamer against a frame-level reference model.
// Follows MATMUL_STREAM_SAT_EN the same way the design does (saturate vs wrap, sat_flag).
module tb_matmul_result_streamer;

  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int M     = 2;
  localparam int N     = 2;
  localparam int BEATS = M * N;

  typedef struct {
    longint data;
    bit     last;
    bit     sat;
  } beat_t;

  logic                    clk   = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    load  = 1'b0;
  logic signed [ACC_W-1:0] c_arr [M][N];
  logic                    busy;
  logic                    load_drop;
  logic                    done;

  matmul_result_streamer_if #(.OUT_W(OUT_W)) m_axis ();

  matmul_result_streamer #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .M     (M),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .C         (c_arr),
    .busy      (busy),
    .load_drop (load_drop),
    .done      (done),
    .m_axis    (m_axis)
  );

  always #5 clk = ~clk;

  beat_t exp_q [$];
  int    checks     = 0;
  int    errors     = 0;
  int    remaining  = 0;
  bit    pend_done  = 1'b0;
  bit    pend_drop  = 1'b0;
  bit    now_valid  = 1'b0;
  bit    now_done   = 1'b0;
  bit    now_drop   = 1'b0;

  // Reference narrowing written directly from the arithmetic definition.
  function automatic beat_t refNarrow(input longint v, input bit last);
    beat_t  b;
    longint hi;
    longint lo;
    longint span;
    hi     = (longint'(1) << (OUT_W - 1)) - 1;
    lo     = -(longint'(1) << (OUT_W - 1));
    span   = longint'(1) << OUT_W;
    b.last = last;
    b.sat  = 1'b0;
    b.data = v;
`ifdef MATMUL_STREAM_SAT_EN
    if (v > hi) begin
      b.data = hi;
      b.sat  = 1'b1;
    end else if (v < lo) begin
      b.data = lo;
      b.sat  = 1'b1;
    end
`else
    b.data = ((((v - lo) % span) + span) % span) + lo;
    if (hi < 0) b.data = v;
`endif
    return b;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setC(input int v00, input int v01, input int v10, input int v11);
    c_arr[0][0] = v00;
    c_arr[0][1] = v01;
    c_arr[1][0] = v10;
    c_arr[1][1] = v11;
  endtask

  task automatic scrambleC();
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 1) == 1) c_arr[r][c] = $urandom;
        else c_arr[r][c] = ACC_W'(int'($urandom_range(0, 200)) - 100);
      end
    end
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after the coming posedge.
  task automatic applyStimulus(input bit ld, input bit rdy);
    bit hs;
    bit fin;
    bit acc;
    @(negedge clk);
    #1;
    now_valid     = (remaining > 0);
    now_done      = pend_done;
    now_drop      = pend_drop;
    if (!ld) scrambleC();
    load          = ld;
    m_axis.tready = rdy;
    hs            = (remaining > 0) && rdy;
    fin           = hs && (remaining == 1);
    acc           = ld && ((remaining == 0) || fin);
    pend_done     = fin;
    pend_drop     = ld && !acc;
    if (hs) remaining--;
    if (acc) begin
      remaining = BEATS;
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          exp_q.push_back(refNarrow(longint'(c_arr[r][c]), (r == M-1) && (c == N-1)));
        end
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    load          = 1'b0;
    m_axis.tready = 1'b0;
    rst_n         = 1'b0;
    #1;
    checkOutput("rst_tvalid", m_axis.tvalid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tlast", m_axis.tlast, 0);
    checkOutput("rst_tdata", m_axis.tdata, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_load_drop", load_drop, 0);
    exp_q.delete();
    remaining = 0;
    pend_done = 1'b0;
    pend_drop = 1'b0;
    now_valid = 1'b0;
    now_done  = 1'b0;
    now_drop  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: samples after the driver has set this cycle's inputs, pops on each handshake.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        checkOutput("tvalid", m_axis.tvalid, now_valid);
        checkOutput("busy", busy, now_valid);
        checkOutput("done", done, now_done);
        checkOutput("load_drop", load_drop, now_drop);
        if (m_axis.tvalid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 1, 0);
          end else begin
            e = exp_q[0];
            checkOutput("tdata", m_axis.tdata, e.data);
            checkOutput("tlast", m_axis.tlast, e.last);
`ifdef MATMUL_STREAM_SAT_EN
            checkOutput("sat_flag", m_axis.sat_flag, e.sat);
`endif
            if (m_axis.tready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    m_axis.tready = 1'b0;
    setC(0, 0, 0, 0);
    doReset();

    $display("[TB] basic frame, tready high");
    setC(1, 2, 3, 4);
    applyStimulus(1'b1, 1'b1);
    repeat (BEATS + 2) applyStimulus(1'b0, 1'b1);

    $display("[TB] frame with stalls");
    setC(1, 2, 3, 4);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, pat[i % 4]);
    repeat (4) applyStimulus(1'b0, 1'b1);

    $display("[TB] back-to-back frames");
    setC(1, 2, 3, 4);
    applyStimulus(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1);
    setC(5, 6, 7, 8);
    applyStimulus(1'b1, 1'b1);
    repeat (BEATS + 2) applyStimulus(1'b0, 1'b1);

    $display("[TB] load during stream is dropped");
    setC(9, 10, 11, 12);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (BEATS + 2) applyStimulus(1'b0, 1'b1);

    $display("[TB] narrowing boundaries");
    setC(40000, -40000, 32767, -5);
    applyStimulus(1'b1, 1'b1);
    repeat (BEATS + 2) applyStimulus(1'b0, 1'b1);
    setC(32768, -32768, -32769, 0);
    applyStimulus(1'b1, 1'b1);
    repeat (BEATS + 2) applyStimulus(1'b0, 1'b1);

    $display("[TB] reset mid-stream");
    setC(21, 22, 23, 24);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    doReset();
    applyStimulus(1'b0, 1'b1);
    setC(31, 32, 33, 34);
    applyStimulus(1'b1, 1'b1);
    repeat (BEATS + 2) applyStimulus(1'b0, 1'b1);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    repeat (20) applyStimulus(1'b0, 1'b1);

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
